seg7_ascii_encoder: RTL and testbench

Reverse path for the segment display peripheral: samples a 7-segment pattern bus, waits for it to settle, maps the pattern back to a 7-bit ASCII code, and queues the characters in a small FIFO that the CPU side drains with a valid/ready handshake. It sits beside the ASCII-to-segment decoder in the ubcd peripheral. It is used for loop-back self-test and for reading segment patterns produced by external display drivers.

---
 rtl/seg7_ascii_encoder_if.sv | 20 ++
 rtl/seg7_ascii_encoder.sv | 164 ++++++++++++++++
 tb/tb_seg7_ascii_encoder.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_ascii_encoder_if.sv
// CPU-side read port of the segment-to-ASCII encoder: FIFO head, handshake and overflow status.
interface seg7_ascii_encoder_if;
  logic       rd_valid;
  logic [6:0] rd_data;
  logic       rd_err;
  logic       rd_ready;
  logic [3:0] fifo_count;
  logic       overflow;
  logic       clr_ovf;

  modport master (
    output rd_valid, rd_data, rd_err, fifo_count, overflow,
    input  rd_ready, clr_ovf
  );

  modport slave (
    input  rd_valid, rd_data, rd_err, fifo_count, overflow,
    output rd_ready, clr_ovf
  );
endinterface

// File: rtl/seg7_ascii_encoder.sv
// Samples a 7-segment bus, debounces it, maps stable patterns to ASCII and queues them in a
// small FIFO drained by the CPU through a valid/ready handshake.
module seg7_ascii_encoder #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [6:0]           seg_in,
  input  logic                 AL,
  seg7_ascii_encoder_if.master rd
);

  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam logic [3:0] CntMax  = 4'(STABLE_CYCLES);
  localparam logic [3:0] CntPush = 4'(STABLE_CYCLES - 1);
  localparam logic [3:0] Depth   = 4'(FIFO_DEPTH);

  logic [6:0]      sync1_q, sync2_q, prev_q, last_q, last_d;
  logic [6:0]      p;
  logic [3:0]      cnt_q, cnt_d;
  logic            push_req;
  logic [6:0]      map_ascii;
  logic            map_err;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      head;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [3:0]      count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            full, pop, push_ok, ovf_set;

  assign p = sync2_q ^ {7{~AL}};

  always_comb begin
    cnt_d = cnt_q;
    if (!en || (p != prev_q)) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // The count reaching STABLE_CYCLES-1 marks the STABLE_CYCLES-th identical sample; saturation
  // above it guarantees a held pattern fires only once.
  assign push_req = en && (p == prev_q) && (cnt_d == CntPush) && (p != last_q);
  assign last_d   = push_req ? p : last_q;

  always_comb begin
    map_ascii = 7'h3F;
    map_err   = 1'b0;
    unique case (p)
      7'h3F: map_ascii = 7'h30;
      7'h06: map_ascii = 7'h31;
      7'h5B: map_ascii = 7'h32;
      7'h4F: map_ascii = 7'h33;
      7'h66: map_ascii = 7'h34;
      7'h6D: map_ascii = 7'h35;
      7'h7D: map_ascii = 7'h36;
      7'h07, 7'h27: map_ascii = 7'h37;
      7'h7F: map_ascii = 7'h38;
      7'h6F, 7'h67: map_ascii = 7'h39;
      7'h77: map_ascii = 7'h41;
      7'h7C: map_ascii = 7'h42;
      7'h39: map_ascii = 7'h43;
      7'h5E: map_ascii = 7'h44;
      7'h79: map_ascii = 7'h45;
      7'h71: map_ascii = 7'h46;
      7'h3D: map_ascii = 7'h47;
      7'h76: map_ascii = 7'h48;
      7'h1E: map_ascii = 7'h4A;
      7'h75: map_ascii = 7'h4B;
      7'h38: map_ascii = 7'h4C;
      7'h2B: map_ascii = 7'h4D;
      7'h37: map_ascii = 7'h4E;
      7'h73: map_ascii = 7'h50;
      7'h31: map_ascii = 7'h52;
      7'h3E: map_ascii = 7'h55;
      7'h6A: map_ascii = 7'h56;
      7'h7E: map_ascii = 7'h57;
      7'h49: map_ascii = 7'h58;
      7'h6E: map_ascii = 7'h59;
      7'h00: map_ascii = 7'h20;
      7'h40: map_ascii = 7'h2D;
      7'h08: map_ascii = 7'h5F;
      7'h01: map_ascii = 7'h7E;
      7'h22: map_ascii = 7'h22;
      7'h42: map_ascii = 7'h27;
      7'h0A: map_ascii = 7'h21;
      7'h48: map_ascii = 7'h3D;
      default: map_err = 1'b1;
    endcase
  end

  assign full    = (count_q == Depth);
  assign pop     = (count_q != 4'd0) && rd.rd_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign push_ok = push_req && (!full || pop);
  assign ovf_set = push_req && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push_ok && !pop) begin
      count_d = count_q + 4'd1;
    end else if (pop && !push_ok) begin
      count_d = count_q - 4'd1;
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (rd.clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      last_q   <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      sync1_q  <= seg_in;
      sync2_q  <= sync1_q;
      prev_q   <= p;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= {map_err, map_ascii};
    end
  end

  assign head          = mem_q[rd_ptr_q];
  assign rd.rd_valid   = (count_q != 4'd0);
  assign rd.rd_data    = rd.rd_valid ? head[6:0] : 7'h00;
  assign rd.rd_err     = rd.rd_valid ? head[7] : 1'b0;
  assign rd.fifo_count = count_q;
  assign rd.overflow   = ovf_q;

endmodule

// File: tb/tb_seg7_ascii_encoder.sv
// Bench for seg7_ascii_encoder: directed scenarios with literal expectations plus random traffic,
// all outputs compared every cycle against a run-length/queue reference model.
module tb_seg7_ascii_encoder;
  localparam int S = 4;
  localparam int D = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en    = 1'b1;
  logic       al    = 1'b1;
  logic [6:0] seg   = 7'h00;
  int         checks = 0;
  int         errors = 0;

  seg7_ascii_encoder_if rif ();

  seg7_ascii_encoder #(
    .STABLE_CYCLES(S),
    .FIFO_DEPTH   (D)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .seg_in(seg),
    .AL    (al),
    .rd    (rif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] amap [logic [6:0]];
  logic [7:0] mq [$];
  logic [6:0] h1 = '0, h2 = '0, pprev = '0, plast = '0;
  int         streak = 0;
  logic       movf = 1'b0;

  task automatic add(input logic [6:0] pat, input logic [7:0] c);
    amap[pat] = c;
  endtask

  function automatic logic [7:0] lookup(input logic [6:0] pat);
    if (amap.exists(pat)) return {1'b0, amap[pat][6:0]};
    return 8'hBF;  // err flag with '?'
  endfunction

  task automatic model_reset();
    h1 = '0; h2 = '0; pprev = '0; plast = '0; streak = 0; movf = 1'b0;
    mq.delete();
  endtask

  task automatic model_edge();
    logic [6:0] pc;
    logic       push, pop, setv;
    pc     = h2 ^ {7{~al}};
    streak = (en && (pc == pprev)) ? streak + 1 : 0;
    push   = (streak == S - 1) && (pc != plast);
    if (push) plast = pc;
    pop  = (mq.size() != 0) && rif.rd_ready;
    setv = 1'b0;
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (mq.size() < D) mq.push_back(lookup(pc));
      else setv = 1'b1;
    end
    if (setv) movf = 1'b1;
    else if (rif.clr_ovf) movf = 1'b0;
    pprev = pc;
    h2    = h1;
    h1    = seg;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_edge();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      begin
        int ev;
        ev = (mq.size() != 0) ? 1 : 0;
        chk("cyc_rd_valid", int'(rif.rd_valid), ev);
        chk("cyc_rd_data", int'(rif.rd_data), ev ? int'(mq[0][6:0]) : 0);
        chk("cyc_rd_err", int'(rif.rd_err), ev ? int'(mq[0][7]) : 0);
        chk("cyc_fifo_count", int'(rif.fifo_count), mq.size());
        chk("cyc_overflow", int'(rif.overflow), int'(movf));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop1();
    rif.rd_ready = 1'b1;
    step(1);
    rif.rd_ready = 1'b0;
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #4 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", int'(rif.rd_valid), 0);
    chk("rst_mid_count", int'(rif.fifo_count), 0);
    #1 rst_n = 1'b1;
  endtask

  logic [6:0] pick [12] = '{7'h3F, 7'h06, 7'h5B, 7'h77, 7'h00, 7'h40, 7'h27, 7'h07,
                            7'h1B, 7'h6E, 7'h42, 7'h7F};
  logic [6:0] ovpats [5] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66};
  logic [6:0] rstpats [3] = '{7'h7F, 7'h6F, 7'h77};

  initial begin
    add(7'h3F, "0"); add(7'h06, "1"); add(7'h5B, "2"); add(7'h4F, "3"); add(7'h66, "4");
    add(7'h6D, "5"); add(7'h7D, "6"); add(7'h07, "7"); add(7'h27, "7"); add(7'h7F, "8");
    add(7'h6F, "9"); add(7'h67, "9");
    add(7'h77, "A"); add(7'h7C, "B"); add(7'h39, "C"); add(7'h5E, "D"); add(7'h79, "E");
    add(7'h71, "F"); add(7'h3D, "G"); add(7'h76, "H"); add(7'h1E, "J"); add(7'h75, "K");
    add(7'h38, "L"); add(7'h2B, "M"); add(7'h37, "N"); add(7'h73, "P"); add(7'h31, "R");
    add(7'h3E, "U"); add(7'h6A, "V"); add(7'h7E, "W"); add(7'h49, "X"); add(7'h6E, "Y");
    add(7'h00, " "); add(7'h40, "-"); add(7'h08, "_"); add(7'h01, "~"); add(7'h22, 8'h22);
    add(7'h42, 8'h27); add(7'h0A, "!"); add(7'h48, "=");

    rif.rd_ready = 1'b0;
    rif.clr_ovf  = 1'b0;
    #2;
    chk("reset_valid", int'(rif.rd_valid), 0);
    chk("reset_data", int'(rif.rd_data), 0);
    chk("reset_err", int'(rif.rd_err), 0);
    chk("reset_count", int'(rif.fifo_count), 0);
    chk("reset_ovf", int'(rif.overflow), 0);
    step(2);
    rst_n = 1'b1;
    step(20);
    chk("blank_valid", int'(rif.rd_valid), 0);
    chk("blank_count", int'(rif.fifo_count), 0);
    chk("blank_ovf", int'(rif.overflow), 0);

    // Latency: pattern applied after edge k is readable after edge k+2+S.
    seg = 7'h5B;
    step(S + 1);
    chk("lat_early_valid", int'(rif.rd_valid), 0);
    step(1);
    chk("lat_valid", int'(rif.rd_valid), 1);
    chk("lat_data", int'(rif.rd_data), 8'h32);
    chk("lat_err", int'(rif.rd_err), 0);
    step(50);
    chk("hold_count", int'(rif.fifo_count), 1);
    pop1();
    chk("pop_count", int'(rif.fifo_count), 0);

    // Active-low polarity and an unmapped pattern.
    al = 1'b0; seg = ~7'h77;
    step(8);
    chk("al0_data", int'(rif.rd_data), 8'h41);
    chk("al0_err", int'(rif.rd_err), 0);
    pop1();
    seg = ~7'h1B;
    step(8);
    chk("unmap_data", int'(rif.rd_data), 8'h3F);
    chk("unmap_err", int'(rif.rd_err), 1);
    pop1();

    // Short glitch is never pushed.
    al = 1'b1; seg = 7'h3F;
    step(8);
    chk("glitch_pre_data", int'(rif.rd_data), 8'h30);
    pop1();
    seg = 7'h06;
    step(S - 1);
    seg = 7'h3F;
    step(10);
    chk("glitch_valid", int'(rif.rd_valid), 0);

    // Enable gating.
    en = 1'b0; seg = 7'h4F;
    step(10);
    chk("en0_valid", int'(rif.rd_valid), 0);
    en = 1'b1;
    step(10);
    chk("en1_count", int'(rif.fifo_count), 1);
    chk("en1_data", int'(rif.rd_data), 8'h33);
    pop1();
    step(20);
    chk("en1_once", int'(rif.fifo_count), 0);

    // Overflow.
    foreach (ovpats[i]) begin
      seg = ovpats[i];
      step(8);
    end
    chk("ovf_count", int'(rif.fifo_count), 4);
    chk("ovf_flag", int'(rif.overflow), 1);
    for (int i = 0; i < 4; i++) begin
      chk("ovf_pop_data", int'(rif.rd_data), 8'h30 + i);
      pop1();
    end
    chk("ovf_drained", int'(rif.fifo_count), 0);
    chk("ovf_sticky", int'(rif.overflow), 1);
    rif.clr_ovf = 1'b1;
    step(1);
    rif.clr_ovf = 1'b0;
    chk("ovf_clr", int'(rif.overflow), 0);

    // Push into a full FIFO with a pop in the same cycle.
    for (int i = 0; i < 4; i++) begin
      seg = ovpats[i];
      step(8);
    end
    seg = 7'h6D;
    step(S + 1);
    rif.rd_ready = 1'b1;
    step(1);
    rif.rd_ready = 1'b0;
    chk("fullpop_count", int'(rif.fifo_count), 4);
    chk("fullpop_ovf", int'(rif.overflow), 0);
    chk("fullpop_head", int'(rif.rd_data), 8'h31);
    rif.rd_ready = 1'b1;
    step(4);
    rif.rd_ready = 1'b0;

    // Reset in the middle of a stream.
    foreach (rstpats[i]) begin
      seg = rstpats[i];
      step(8);
    end
    chk("mid_count", int'(rif.fifo_count), 3);
    mid_reset();
    step(10);
    chk("post_rst_count", int'(rif.fifo_count), 1);
    chk("post_rst_data", int'(rif.rd_data), 8'h41);
    pop1();
    seg = 7'h00;
    step(8);
    chk("blank_push_data", int'(rif.rd_data), 8'h20);
    pop1();
    mid_reset();
    step(10);
    chk("post_rst_blank", int'(rif.fifo_count), 0);

    // Random traffic, checked every cycle by the model.
    for (int i = 0; i < 400; i++) begin
      int hold;
      hold = $urandom_range(1, 8);
      if ($urandom_range(0, 19) == 0) al = ~al;
      if ($urandom_range(0, 3) == 0) seg = 7'($urandom);
      else seg = pick[$urandom_range(0, 11)] ^ {7{~al}};
      en = ($urandom_range(0, 9) != 0);
      if (i == 200) mid_reset();
      for (int j = 0; j < hold; j++) begin
        rif.rd_ready = ($urandom_range(0, 2) == 0);
        rif.clr_ovf  = ($urandom_range(0, 15) == 0);
        step(1);
      end
    end
    rif.rd_ready = 1'b0;
    rif.clr_ovf  = 1'b0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
